redmule_tcdm_responder: RTL and testbench



---
 rtl/redmule_tcdm_responder.sv | 147 ++++++++++++++
 tb/tb_redmule_tcdm_responder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/redmule_tcdm_responder.sv
// TCDM target responder: byte-enabled scratchpad with a fixed-latency read pipeline
// and a fall-through response FIFO whose credits gate the request grant.
module redmule_tcdm_responder #(
  parameter int DW          = 288,
  parameter int AW          = 32,
  parameter int UW          = 1,
  parameter int IW          = 8,
  parameter int DEPTH       = 256,
  parameter int WORD_STRIDE = 64,
  parameter int LATENCY     = 1,
  parameter int RSP_DEPTH   = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             clear_i,
  input  logic                             stall_i,
  input  logic                             tcdm_req_i,
  output logic                             tcdm_gnt_o,
  input  logic [AW-1:0]                    tcdm_add_i,
  input  logic                             tcdm_wen_i,
  input  logic [DW/8-1:0]                  tcdm_be_i,
  input  logic [DW-1:0]                    tcdm_data_i,
  input  logic [UW-1:0]                    tcdm_user_i,
  input  logic [IW-1:0]                    tcdm_id_i,
  output logic                             tcdm_r_valid_o,
  input  logic                             tcdm_r_ready_i,
  output logic [DW-1:0]                    tcdm_r_data_o,
  output logic [UW-1:0]                    tcdm_r_user_o,
  output logic [IW-1:0]                    tcdm_r_id_o,
  output logic                             tcdm_r_opc_o,
  output logic [$clog2(RSP_DEPTH+1)-1:0]   outstanding_o
);

  localparam int BW  = DW / 8;
  localparam int CW  = $clog2(RSP_DEPTH + 1);
  localparam int OFS = $clog2(WORD_STRIDE);
  localparam int IXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [UW-1:0] user;
    logic [IW-1:0] id;
  } rsp_t;

  logic [IXW-1:0] idx;
  logic           gnt, wr_hs, rd_hs;
  logic [CW-1:0]  cnt_q, cnt_d;

  assign idx   = tcdm_add_i[OFS +: IXW];
  // Reset also forces the grant low so every output reads 0 while rst_i is high.
  assign gnt   = tcdm_req_i & ~stall_i & ~clear_i & ~rst_i & (cnt_q < CW'(RSP_DEPTH));
  assign wr_hs = gnt & ~tcdm_wen_i;
  assign rd_hs = gnt & tcdm_wen_i;

  logic [DW-1:0] mem_q [DEPTH];

  // NOTE: storage arrays carry no reset; only control state is reset.
  always_ff @(posedge clk_i) begin
    if (wr_hs) begin
      for (int i = 0; i < BW; i++) begin
        if (tcdm_be_i[i]) mem_q[idx][8*i +: 8] <= tcdm_data_i[8*i +: 8];
      end
    end
  end

  logic [LATENCY-1:0] stg_vld_q, stg_vld_d;
  rsp_t               stg_q [LATENCY];
  logic               tail_vld;
  rsp_t               tail;

  always_comb begin
    stg_vld_d    = '0;
    stg_vld_d[0] = rd_hs;
    for (int i = 1; i < LATENCY; i++) stg_vld_d[i] = stg_vld_q[i-1];
    if (clear_i) stg_vld_d = '0;
  end

  always_ff @(posedge clk_i) begin
    stg_q[0] <= '{data: mem_q[idx], user: tcdm_user_i, id: tcdm_id_i};
    for (int i = 1; i < LATENCY; i++) stg_q[i] <= stg_q[i-1];
  end

  assign tail_vld = stg_vld_q[LATENCY-1];
  assign tail     = stg_q[LATENCY-1];

  rsp_t          fifo_q [RSP_DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] fcnt_q, fcnt_d;
  logic          fifo_empty, push, fifo_pop, pop, rsp_vld;
  rsp_t          head;

  // With an empty FIFO the pipeline tail bypasses it, so the first response
  // appears exactly LATENCY cycles after its grant.
  assign fifo_empty = (fcnt_q == '0);
  assign rsp_vld    = ~fifo_empty | tail_vld;
  assign head       = fifo_empty ? tail : fifo_q[rptr_q];
  assign pop        = rsp_vld & tcdm_r_ready_i;
  assign fifo_pop   = ~fifo_empty & tcdm_r_ready_i;
  assign push       = tail_vld & ~(fifo_empty & tcdm_r_ready_i);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    fcnt_d = fcnt_q;
    cnt_d  = cnt_q + CW'(rd_hs) - CW'(pop);
    if (push)     wptr_d = (wptr_q == PW'(RSP_DEPTH - 1)) ? '0 : wptr_q + 1'b1;
    if (fifo_pop) rptr_d = (rptr_q == PW'(RSP_DEPTH - 1)) ? '0 : rptr_q + 1'b1;
    fcnt_d = fcnt_q + CW'(push) - CW'(fifo_pop);
    if (clear_i) begin
      wptr_d = '0;
      rptr_d = '0;
      fcnt_d = '0;
      cnt_d  = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stg_vld_q <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      fcnt_q    <= '0;
      cnt_q     <= '0;
    end else begin
      stg_vld_q <= stg_vld_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      fcnt_q    <= fcnt_d;
      cnt_q     <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !clear_i) fifo_q[wptr_q] <= tail;
  end

  assign tcdm_gnt_o     = gnt;
  assign tcdm_r_valid_o = rsp_vld;
  assign tcdm_r_data_o  = rsp_vld ? head.data : '0;
  assign tcdm_r_user_o  = rsp_vld ? head.user : '0;
  assign tcdm_r_id_o    = rsp_vld ? head.id   : '0;
  assign tcdm_r_opc_o   = 1'b0;
  assign outstanding_o  = cnt_q;

endmodule

// File: tb/tb_redmule_tcdm_responder.sv
// Directed bench for redmule_tcdm_responder: a queue-based memory/response model
// checked every cycle, plus literal expectations for each scenario.
module tb_redmule_tcdm_responder;

  localparam int DW = 288, AW = 32, UW = 1, IW = 8;
  localparam int DEPTH = 256, WORD_STRIDE = 64, LATENCY = 1, RSP_DEPTH = 4;
  localparam int BW = DW / 8;
  localparam int CW = $clog2(RSP_DEPTH + 1);

  logic          clk = 1'b0, rst, clear, stall, req, gnt, wen, r_valid, r_ready, r_opc;
  logic [AW-1:0] add;
  logic [BW-1:0] be;
  logic [DW-1:0] wdata, r_data;
  logic [UW-1:0] user, r_user;
  logic [IW-1:0] id, r_id;
  logic [CW-1:0] outstanding;

  redmule_tcdm_responder #(
    .DW(DW), .AW(AW), .UW(UW), .IW(IW), .DEPTH(DEPTH),
    .WORD_STRIDE(WORD_STRIDE), .LATENCY(LATENCY), .RSP_DEPTH(RSP_DEPTH)
  ) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .stall_i(stall),
    .tcdm_req_i(req), .tcdm_gnt_o(gnt), .tcdm_add_i(add), .tcdm_wen_i(wen),
    .tcdm_be_i(be), .tcdm_data_i(wdata), .tcdm_user_i(user), .tcdm_id_i(id),
    .tcdm_r_valid_o(r_valid), .tcdm_r_ready_i(r_ready), .tcdm_r_data_o(r_data),
    .tcdm_r_user_o(r_user), .tcdm_r_id_o(r_id), .tcdm_r_opc_o(r_opc),
    .outstanding_o(outstanding)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: word-addressed memory plus an ordered queue of pending responses,
  // each tagged with the cycle it becomes visible.
  typedef struct {
    logic [DW-1:0] d;
    logic [IW-1:0] id;
    logic [UW-1:0] u;
    int            rdy;
  } exp_t;

  logic [DW-1:0] mm [DEPTH];
  exp_t          q[$];
  logic [IW-1:0] popped[$];
  int            cyc = 0, gnt_cnt = 0;

  always @(negedge clk) begin
    logic exp_gnt, exp_rv;
    int   w;
    cyc++;
    check("r_opc", DW'(r_opc), '0);
    if (rst) begin
      q.delete();
      check("rst_gnt", DW'(gnt), '0);
      check("rst_r_valid", DW'(r_valid), '0);
      check("rst_outstanding", DW'(outstanding), '0);
    end else begin
      exp_gnt = req && !stall && !clear && (q.size() < RSP_DEPTH);
      exp_rv  = (q.size() > 0) && (q[0].rdy <= cyc);
      check("gnt", DW'(gnt), DW'(exp_gnt));
      check("outstanding", DW'(outstanding), DW'(q.size()));
      check("r_valid", DW'(r_valid), DW'(exp_rv));
      if (exp_rv && r_valid) begin
        check("r_data", r_data, q[0].d);
        check("r_id", DW'(r_id), DW'(q[0].id));
        check("r_user", DW'(r_user), DW'(q[0].u));
      end
      if (gnt && req) gnt_cnt++;
      if (clear) q.delete();
      else begin
        if (exp_rv && r_ready) begin
          popped.push_back(q[0].id);
          void'(q.pop_front());
        end
        if (exp_gnt) begin
          w = int'((add / WORD_STRIDE) % DEPTH);
          if (wen) q.push_back('{d: mm[w], id: id, u: user, rdy: cyc + LATENCY});
          else for (int b = 0; b < BW; b++) if (be[b]) mm[w][8*b +: 8] = wdata[8*b +: 8];
        end
      end
    end
  end

  // Presents one request and holds it until granted; returns 1 ns after the grant edge.
  task automatic issue(input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [BW-1:0] e, input logic [IW-1:0] i);
    logic g;
    int   n;
    req = 1'b1; wen = rd; add = a; wdata = d; be = e; id = i; user = i[0];
    g = 1'b0;
    for (n = 0; n < 40 && !g; n++) begin
      @(negedge clk);
      g = gnt;
      @(posedge clk);
      #1;
    end
    if (!g) check("issue_timeout", DW'(g), DW'(1'b1));
    req = 1'b0;
  endtask

  localparam logic [DW-1:0] PAT_A5 = {BW{8'hA5}};
  localparam logic [DW-1:0] PAT_BE = {{(BW-4){8'hFF}}, 32'h0};
  localparam logic [DW-1:0] PAT_W3 = {9{32'hDEADBEEF}};

  initial begin
    int g0, n;
    rst = 1'b1; clear = 1'b0; stall = 1'b0; req = 1'b0; wen = 1'b1; add = '0;
    be = '0; wdata = '0; user = '0; id = '0; r_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Write then read: response one cycle after the read grant.
    issue(1'b0, 32'h40, PAT_A5, '1, 8'h00);
    issue(1'b1, 32'h40, '0, '0, 8'h3C);
    check("wr_rd_valid", DW'(r_valid), DW'(1'b1));
    check("wr_rd_data", r_data, PAT_A5);
    check("wr_rd_id", DW'(r_id), DW'(8'h3C));

    // Byte-enable merge.
    issue(1'b0, 32'h80, '1, '1, 8'h00);
    issue(1'b0, 32'h80, '0, 36'hF, 8'h00);
    issue(1'b1, 32'h80, '0, '0, 8'h11);
    check("be_data", r_data, PAT_BE);

    // Address wrap modulo DEPTH.
    issue(1'b0, 32'(3 * 64), PAT_W3, '1, 8'h00);
    issue(1'b1, 32'(3 * 64 + 256 * 64), '0, '0, 8'h22);
    check("wrap_data", r_data, PAT_W3);
    repeat (3) @(posedge clk);
    #1;

    // Back-pressure: four grants fill the credits, the rest wait for r_ready.
    popped.delete();
    r_ready = 1'b0;
    g0 = gnt_cnt;
    for (int i = 0; i < 4; i++) issue(1'b1, 32'(64 + (i % 3) * 64), '0, '0, IW'(i));
    req = 1'b1; wen = 1'b1; add = 32'h40; id = 8'd4; user = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("bp_grants", DW'(gnt_cnt - g0), DW'(4));
    check("bp_outstanding", DW'(outstanding), DW'(4));
    check("bp_gnt_low", DW'(gnt), '0);
    @(posedge clk);
    #1 r_ready = 1'b1;
    issue(1'b1, 32'h40, '0, '0, 8'd4);
    issue(1'b1, 32'h80, '0, '0, 8'd5);
    for (n = 0; n < 30 && popped.size() < 6; n++) @(posedge clk);
    check("bp_count", DW'(popped.size()), DW'(6));
    for (int i = 0; i < 6 && i < popped.size(); i++) check("bp_order", DW'(popped[i]), DW'(i));
    #1;

    // Clear with three reads outstanding.
    r_ready = 1'b0;
    for (int i = 0; i < 3; i++) issue(1'b1, 32'h40, '0, '0, IW'(8'h30 + i));
    check("clr_pre", DW'(outstanding), DW'(3));
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    check("clr_outstanding", DW'(outstanding), '0);
    check("clr_valid", DW'(r_valid), '0);
    r_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("clr_quiet", DW'(r_valid), '0);
    @(posedge clk);
    #1;

    // Stall holds the grant low for five cycles, then the read proceeds.
    stall = 1'b1; req = 1'b1; wen = 1'b1; add = 32'h40; id = 8'h55;
    g0 = gnt_cnt;
    repeat (5) @(negedge clk);
    #1 check("stall_grants", DW'(gnt_cnt - g0), '0);
    @(posedge clk);
    #1 stall = 1'b0;
    issue(1'b1, 32'h40, '0, '0, 8'h55);
    check("stall_data", r_data, PAT_A5);
    @(posedge clk);
    #1;

    // Asynchronous reset with a response pending.
    r_ready = 1'b0;
    issue(1'b1, 32'h80, '0, '0, 8'h66);
    check("rst_pre_valid", DW'(r_valid), DW'(1'b1));
    #2 rst = 1'b1; req = 1'b1; wen = 1'b1; add = 32'h40;
    #1;
    check("async_valid", DW'(r_valid), '0);
    check("async_gnt", DW'(gnt), '0);
    check("async_outstanding", DW'(outstanding), '0);
    @(posedge clk);
    #1 rst = 1'b0; req = 1'b0; r_ready = 1'b1;
    issue(1'b1, 32'h40, '0, '0, 8'h77);
    check("post_rst_data", r_data, PAT_A5);
    issue(1'b1, 32'(3 * 64), '0, '0, 8'h78);
    check("post_rst_w3", r_data, PAT_W3);
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
